// File: rtl/output_port_arbiter.sv
// Wormhole switch allocator for one router output port. Round-robin grants the
// port to an input presenting a head flit routed here, holds the grant until the
// tail flit transfers, and muxes the owner's flit straight onto the output link.
module output_port_arbiter #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned FLIT_W  = 10,
  parameter logic [2:0]  PORT_ID = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  input  logic [NUM_IN*3-1:0]      in_route,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [2:0]               grant_id
);

  localparam logic [1:0] TypeHead = 2'b11;
  localparam logic [1:0] TypeTail = 2'b10;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0]  req;
  logic               found;
  logic [2:0]         winner;
  logic [2:0]         idx;
  logic               owner_valid;
  logic [FLIT_W-1:0]  owner_flit;
  logic [NUM_IN-1:0]  owner_onehot;
  logic               xfer;

  // An input requests only with a head flit whose route targets this port.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      req[i] = in_valid[i] && (in_route[i*3 +: 3] == PORT_ID) &&
               (in_flit[i*FLIT_W +: 2] == TypeHead);
    end
  end

  // Round-robin pick: scan starting just after the last granted input.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = 3'((32'(rr_ptr_q) + 32'(k)) % NUM_IN);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Select the owner's valid/flit and its one-hot pop position.
  always_comb begin
    owner_valid  = 1'b0;
    owner_flit   = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner_q == 3'(i)) begin
        owner_valid     = in_valid[i];
        owner_flit      = in_flit[i*FLIT_W +: FLIT_W];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and output logic of the lock FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    in_ready  = '0;
    out_valid = 1'b0;
    out_flit  = '0;
    busy      = 1'b0;
    grant_id  = '0;
    xfer      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = winner;
          state_d = StLocked;
        end
      end
      StLocked: begin
        busy      = 1'b1;
        grant_id  = owner_q;
        out_valid = owner_valid;
        out_flit  = owner_flit;
        xfer      = owner_valid && out_ready;
        in_ready  = xfer ? owner_onehot : '0;
        // Any non-tail type, including a stray head, is forwarded as data.
        if (xfer && (owner_flit[1:0] == TypeTail)) begin
          state_d  = StIdle;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= 3'(NUM_IN - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int N = 5;
  localparam int W = 10;
  localparam logic [2:0] P = 3'b011;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_flit = '0;
  logic [N*3-1:0] in_route = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_flit;
  logic           out_ready = 1'b0;
  logic           busy;
  logic [2:0]     grant_id;

  int errors = 0;
  int checks = 0;

  // Upstream flit queues with per-flit route code.
  logic [W-1:0] fq[N][$];
  logic [2:0]   rq[N][$];
  bit           hold_off[N];
  logic [N-1:0] rdy;

  // Reference model state: lock flag, owner, last granted input.
  bit m_locked;
  int m_owner;
  int m_last;

  always #5 clk = ~clk;

  output_port_arbiter #(.NUM_IN(N), .FLIT_W(W), .PORT_ID(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_flit  (in_flit),
    .in_route (in_route),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_flit (out_flit),
    .out_ready(out_ready),
    .busy     (busy),
    .grant_id (grant_id)
  );

  function automatic logic [W-1:0] mk(input logic [7:0] pl, input logic [1:0] ty);
    return {pl, ty};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() > 0) begin
        in_valid[i]       = !hold_off[i];
        in_flit[i*W +: W] = fq[i][0];
        in_route[i*3 +: 3] = rq[i][0];
      end else begin
        in_valid[i]       = 1'b0;
        in_flit[i*W +: W] = '0;
        in_route[i*3 +: 3] = P;
      end
    end
  endtask

  task automatic push_pkt(input int i, input logic [2:0] r, input logic [7:0] tag,
                          input int nbody, input bit mixed);
    logic [1:0] ty;
    fq[i].push_back(mk(tag, 2'b11));
    rq[i].push_back(r);
    for (int j = 1; j <= nbody; j++) begin
      ty = 2'b01;
      if (mixed) begin
        case ($urandom_range(0, 5))
          0: ty = 2'b00;
          1: ty = 2'b11;
          default: ty = 2'b01;
        endcase
      end
      fq[i].push_back(mk(tag + 8'(j), ty));
      rq[i].push_back(r);
    end
    fq[i].push_back(mk(tag + 8'(nbody + 1), 2'b10));
    rq[i].push_back(r);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
  endtask

  // Packet-level rules: tail transfer releases the port; otherwise the first
  // head requester after the last winner (cyclically) takes it.
  task automatic model_update();
    bit got;
    int c;
    if (m_locked) begin
      if (in_valid[m_owner] && out_ready && in_flit[m_owner*W +: 2] == 2'b10) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end else begin
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!got && in_valid[c] && in_route[c*3 +: 3] == P && in_flit[c*W +: 2] == 2'b11) begin
          got      = 1'b1;
          m_locked = 1'b1;
          m_owner  = c;
        end
      end
    end
  endtask

  task automatic settle();
    drive();
    @(negedge clk);
  endtask

  task automatic tick();
    rdy = in_ready;
    model_update();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && fq[i].size() > 0) begin
        void'(fq[i].pop_front());
        void'(rq[i].pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      rq[i].delete();
      hold_off[i] = 1'b0;
    end
    out_ready = 1'b0;
    reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    push_pkt(4, P, 8'h40, 0, 1'b0);
    push_pkt(0, P, 8'h00, 0, 1'b0);
    settle();
    checks++; if (in_ready !== 5'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 00000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_flit !== '0) begin errors++; $display("FAIL reset_out_flit: got %h want 000", out_flit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tick();
    settle();
    // Input 0 must win the first arbitration out of reset.
    checks++; if (grant_id !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL reset_first_grant: got id=%0d busy=%b want id=0 busy=1", grant_id, busy); end
  endtask

  task automatic test_single_packet();
    logic [W-1:0] exp_f[4];
    do_reset();
    out_ready = 1'b1;
    push_pkt(2, P, 8'h21, 2, 1'b0);
    for (int j = 0; j < 4; j++) exp_f[j] = fq[2][j];
    settle();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_arb_cycle: got ov=%b busy=%b want 0 0", out_valid, busy); end
    tick();
    for (int j = 0; j < 4; j++) begin
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_ov[%0d]: got %b want 1", j, out_valid); end
      checks++; if (out_flit !== exp_f[j]) begin errors++; $display("FAIL single_flit[%0d]: got %h want %h", j, out_flit, exp_f[j]); end
      checks++; if (in_ready !== 5'b00100) begin errors++; $display("FAIL single_ready[%0d]: got %b want 00100", j, in_ready); end
      checks++; if (busy !== 1'b1 || grant_id !== 3'd2) begin errors++; $display("FAIL single_owner[%0d]: got busy=%b id=%0d want 1 2", j, busy, grant_id); end
      tick();
    end
    settle();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_release: got busy=%b ov=%b want 0 0", busy, out_valid); end
    tick();
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 4, 0, 1, 4};
    int pk[N];
    logic [7:0] tag;
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, P, 8'(0 * 16 + p * 2), 0, 1'b0);
      push_pkt(1, P, 8'(1 * 16 + p * 2), 0, 1'b0);
      push_pkt(4, P, 8'(4 * 16 + p * 2), 0, 1'b0);
    end
    for (int i = 0; i < N; i++) pk[i] = 0;
    for (int p = 0; p < 6; p++) begin
      tag = 8'(order[p] * 16 + pk[order[p]] * 2);
      pk[order[p]]++;
      settle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got busy=%b want 0", p, busy); end
      tick();
      settle();
      checks++; if (busy !== 1'b1 || grant_id !== 3'(order[p])) begin errors++; $display("FAIL rr_grant[%0d]: got busy=%b id=%0d want 1 %0d", p, busy, grant_id, order[p]); end
      checks++; if (out_flit !== mk(tag, 2'b11)) begin errors++; $display("FAIL rr_head[%0d]: got %h want %h", p, out_flit, mk(tag, 2'b11)); end
      tick();
      settle();
      checks++; if (in_ready !== 5'(1 << order[p]) || out_flit !== mk(tag + 8'd1, 2'b10)) begin errors++; $display("FAIL rr_tail[%0d]: got rdy=%b flit=%h want %b %h", p, in_ready, out_flit, 5'(1 << order[p]), mk(tag + 8'd1, 2'b10)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_f[5];
    do_reset();
    out_ready = 1'b1;
    push_pkt(3, P, 8'h30, 3, 1'b0);
    for (int j = 0; j < 5; j++) exp_f[j] = fq[3][j];
    settle(); tick();
    for (int j = 0; j < 2; j++) begin
      settle();
      checks++; if (out_flit !== exp_f[j]) begin errors++; $display("FAIL bp_pre[%0d]: got %h want %h", j, out_flit, exp_f[j]); end
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      checks++; if (out_flit !== exp_f[2] || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_flit[%0d]: got %h ov=%b want %h 1", s, out_flit, out_valid, exp_f[2]); end
      checks++; if (in_ready !== 5'b0 || grant_id !== 3'd3) begin errors++; $display("FAIL bp_hold_ctl[%0d]: got rdy=%b id=%0d want 00000 3", s, in_ready, grant_id); end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 2; j < 5; j++) begin
      settle();
      checks++; if (out_flit !== exp_f[j] || in_ready !== 5'b01000) begin errors++; $display("FAIL bp_resume[%0d]: got %h rdy=%b want %h 01000", j, out_flit, in_ready, exp_f[j]); end
      tick();
    end
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_wormhole_lock();
    logic [W-1:0] f1[4];
    logic [W-1:0] f0[3];
    do_reset();
    out_ready = 1'b1;
    push_pkt(1, P, 8'h10, 2, 1'b0);
    for (int j = 0; j < 4; j++) f1[j] = fq[1][j];
    settle(); tick();
    push_pkt(0, P, 8'h80, 1, 1'b0);
    for (int j = 0; j < 3; j++) f0[j] = fq[0][j];
    for (int j = 0; j < 4; j++) begin
      settle();
      checks++; if (grant_id !== 3'd1 || out_flit !== f1[j] || in_ready !== 5'b00010) begin errors++; $display("FAIL lock_owner1[%0d]: got id=%0d flit=%h rdy=%b want 1 %h 00010", j, grant_id, out_flit, in_ready, f1[j]); end
      tick();
    end
    settle();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 5'b0) begin errors++; $display("FAIL lock_bubble: got busy=%b ov=%b rdy=%b want 0 0 00000", busy, out_valid, in_ready); end
    tick();
    for (int j = 0; j < 3; j++) begin
      settle();
      checks++; if (grant_id !== 3'd0 || out_flit !== f0[j] || in_ready !== 5'b00001) begin errors++; $display("FAIL lock_owner0[%0d]: got id=%0d flit=%h rdy=%b want 0 %h 00001", j, grant_id, out_flit, in_ready, f0[j]); end
      tick();
    end
  endtask

  task automatic test_filter_reset();
    do_reset();
    out_ready = 1'b1;
    push_pkt(2, P ^ 3'b001, 8'h50, 0, 1'b0);
    fq[4].push_back(mk(8'h60, 2'b01));
    rq[4].push_back(P);
    for (int s = 0; s < 3; s++) begin
      settle();
      checks++; if (busy !== 1'b0 || in_ready !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL filter_nogrant[%0d]: got busy=%b rdy=%b ov=%b want 0 00000 0", s, busy, in_ready, out_valid); end
      tick();
    end
    for (int i = 0; i < N; i++) begin fq[i].delete(); rq[i].delete(); end
    push_pkt(3, P, 8'h70, 2, 1'b0);
    settle(); tick();
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_locked: got busy=%b want 1", busy); end
    tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin fq[i].delete(); rq[i].delete(); end
    settle();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL midreset_idle: got busy=%b ov=%b id=%0d want 0 0 0", busy, out_valid, grant_id); end
    tick();
  endtask

  task automatic test_random();
    logic [2:0]   r;
    logic [W-1:0] f;
    logic         e_ov;
    logic [W-1:0] e_of;
    logic [N-1:0] e_rdy;
    logic [2:0]   e_gid;
    bit           done;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (fq[i].size() > 0 && fq[i][0][1:0] == 2'b11 && rq[i][0] != P &&
            $urandom_range(0, 2) == 0) begin
          // Another output port consumes this packet.
          done = 1'b0;
          while (!done && fq[i].size() > 0) begin
            f = fq[i].pop_front();
            void'(rq[i].pop_front());
            if (f[1:0] == 2'b10) done = 1'b1;
          end
        end
        if (fq[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          r = P;
          if ($urandom_range(0, 3) == 0) begin
            r = 3'($urandom_range(0, 7));
            if (r == P) r = r ^ 3'b001;
          end
          push_pkt(i, r, 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
        hold_off[i] = ($urandom_range(0, 4) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      e_ov  = m_locked && in_valid[m_owner];
      e_of  = m_locked ? in_flit[m_owner*W +: W] : '0;
      e_rdy = (e_ov && out_ready) ? 5'(1 << m_owner) : 5'b0;
      e_gid = m_locked ? 3'(m_owner) : 3'd0;
      checks++; if (out_valid !== e_ov) begin errors++; $display("FAIL rand_ov@%0d: got %b want %b", cyc, out_valid, e_ov); end
      checks++; if (out_flit !== e_of) begin errors++; $display("FAIL rand_flit@%0d: got %h want %h", cyc, out_flit, e_of); end
      checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, in_ready, e_rdy); end
      checks++; if (busy !== m_locked) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, busy, m_locked); end
      checks++; if (grant_id !== e_gid) begin errors++; $display("FAIL rand_gid@%0d: got %0d want %0d", cyc, grant_id, e_gid); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) hold_off[i] = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_wormhole_lock();
    test_filter_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
